// File: rtl/sck_control_master.sv
// SPI master serial-clock generator: divides clk into SCK_out, frames DATA_BITS bits
// per start request and emits single-cycle shift/sample strobes for all CPOL/CPHA modes.
module sck_control_master #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 CPOL,
    input  logic                 CPHA,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 SCK_out,
    output logic                 Shift_en,
    output logic                 Sample_en,
    output logic                 busy,
    output logic                 idle,
    output logic                 done
);

    localparam int EC_W = (2 * DATA_BITS > 1) ? $clog2(2 * DATA_BITS) : 1;
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_TAIL   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state;
    logic                 r_cpol,   w_cpol;
    logic                 r_cpha,   w_cpha;
    logic [DIV_WIDTH-1:0] r_div,    w_div;
    logic [DIV_WIDTH-1:0] r_hc,     w_hc;
    logic [EC_W-1:0]      r_ec,     w_ec;
    logic                 r_sck,    w_sck;
    logic                 r_shift,  w_shift;
    logic                 r_sample, w_sample;
    logic                 r_busy,   w_busy;
    logic                 r_idle,   w_idle;
    logic                 r_done,   w_done;
    logic                 w_hc_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_div    <= '0;
            r_hc     <= '0;
            r_ec     <= '0;
            r_sck    <= 1'b0;
            r_shift  <= 1'b0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cpol   <= w_cpol;
            r_cpha   <= w_cpha;
            r_div    <= w_div;
            r_hc     <= w_hc;
            r_ec     <= w_ec;
            r_sck    <= w_sck;
            r_shift  <= w_shift;
            r_sample <= w_sample;
            r_busy   <= w_busy;
            r_idle   <= w_idle;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cpol   = r_cpol;
        w_cpha   = r_cpha;
        w_div    = r_div;
        w_hc     = r_hc;
        w_ec     = r_ec;
        w_sck    = r_sck;
        w_shift  = 1'b0;
        w_sample = 1'b0;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_hc_hit = (r_hc == r_div);

        case (r_state)
            S_IDLE: begin
                w_sck = CPOL;
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !abort && !r_done) begin
                    w_state = S_ACTIVE;
                    w_cpol  = CPOL;
                    w_cpha  = CPHA;
                    w_div   = baud_div;
                    w_hc    = '0;
                    w_ec    = '0;
                    w_busy  = 1'b1;
                    w_shift = ~CPHA;
                end
            end

            S_ACTIVE: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_sck   = r_cpol;
                    w_busy  = 1'b0;
                    w_hc    = '0;
                    w_ec    = '0;
                end else if (w_hc_hit) begin
                    w_sck = ~r_sck;
                    w_hc  = '0;
                    w_ec  = r_ec + EC_W'(1);
                    if (!r_ec[0]) begin
                        w_shift  = r_cpha;
                        w_sample = ~r_cpha;
                    end else begin
                        // CPHA=0 has no bit left to drive after the final trailing edge.
                        w_shift  = ~r_cpha && (r_ec != EC_LAST);
                        w_sample = r_cpha;
                    end
                    if (r_ec == EC_LAST) begin
                        w_state = S_TAIL;
                        w_ec    = '0;
                    end
                end else begin
                    w_hc = r_hc + DIV_WIDTH'(1);
                end
            end

            S_TAIL: begin
                if (abort) begin
                    w_state = S_IDLE;
                    w_sck   = r_cpol;
                    w_busy  = 1'b0;
                    w_hc    = '0;
                    w_ec    = '0;
                end else if (w_hc_hit) begin
                    w_state = S_IDLE;
                    w_hc    = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_hc = r_hc + DIV_WIDTH'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_hc    = '0;
                w_ec    = '0;
            end
        endcase

        w_idle = ~w_busy;
    end

    assign SCK_out   = r_sck;
    assign Shift_en  = r_shift;
    assign Sample_en = r_sample;
    assign busy      = r_busy;
    assign idle      = r_idle;
    assign done      = r_done;

endmodule

// File: doc/sck_control_master.md
Name: sck_control_master

Overview:
- Master-side SPI serial clock generator, the counterpart of the slave SCK control block.
- Divides the system clock into SCK_out and emits single-cycle shift/sample strobes that drive the master shift register for all four CPOL/CPHA modes.
- Frames exactly DATA_BITS bits per start request and reports busy/idle/done to the SPI master controller.

Parameters:
- DATA_BITS, 8, bits per transfer (>=1).
- DIV_WIDTH, 8, width of baud_div.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  transfer request; accepted only in IDLE.
- abort  input  1  synchronous abort, returns to IDLE.
- CPOL  input  1  clock polarity.
- CPHA  input  1  clock phase.
- baud_div  input  DIV_WIDTH  SCK half-period minus one, in clk cycles.
- SCK_out  output  1  serial clock to pad.
- Shift_en  output  1  one-cycle strobe: drive next MOSI bit.
- Sample_en  output  1  one-cycle strobe: capture MISO.
- busy  output  1  transfer in progress.
- idle  output  1  inverse of busy.
- done  output  1  one-cycle end-of-transfer pulse.

Behaviour:
- All outputs are registered.
- Reset values: SCK_out=0, Shift_en=0, Sample_en=0, busy=0, done=0, idle=1. All counters and state clear to 0/IDLE.
- Reset asserted mid-transfer forces reset values immediately; no done pulse is produced.
- States: IDLE, ACTIVE, TAIL.
- IDLE:
  - SCK_out follows the CPOL input one cycle later.
  - start=1 (abort=0) at clock edge T: latch CPOL, CPHA and baud_div; clear half-period counter hc and edge counter ec; go to ACTIVE.
  - If CPHA=0, Shift_en=1 in cycle T+1 (first bit setup).
- ACTIVE:
  - hc increments each cycle.
  - When hc==latched baud_div: toggle SCK_out, hc:=0, ec:=ec+1.
  - Even ec (leading edge):
    - CPHA=0: Sample_en=1.
    - CPHA=1: Shift_en=1.
  - Odd ec (trailing edge):
    - CPHA=0: Shift_en=1, except on the final edge ec=2*DATA_BITS-1, where it is suppressed.
    - CPHA=1: Sample_en=1.
  - Strobes coincide with the cycle in which the new SCK_out level is visible.
  - After edge ec=2*DATA_BITS-1, go to TAIL. SCK_out is back at the latched CPOL level.
- TAIL:
  - Count baud_div+1 cycles, then go to IDLE.
  - done=1 for one cycle, coinciding with busy falling and idle rising.
  - Total: done asserted exactly (2*DATA_BITS+1)*(baud_div+1) cycles after edge T.
- Strobe counts per transfer:
  - CPHA=0: DATA_BITS Shift_en (including the initial one) and DATA_BITS Sample_en.
  - CPHA=1: DATA_BITS of each.
  - Shift_en and Sample_en are never high in the same cycle.
- busy=1 from T+1 until the done cycle.
- start while busy is ignored, including start in the same cycle as done.
- Changes to CPOL/CPHA/baud_div while busy have no effect until the next start.
- abort=1 in ACTIVE or TAIL:
  - Next cycle: state=IDLE, SCK_out=latched CPOL, strobes=0, busy=0, done=0.
  - abort has priority over start; abort in IDLE has no effect.
- baud_div=0 gives SCK = clk/2. Max divisor gives half-period 2^DIV_WIDTH cycles; hc is DIV_WIDTH bits wide and does not wrap mid-count.
- ec is $clog2(2*DATA_BITS) bits wide.

Test Plan:
- Mode 0, DATA_BITS=8, baud_div=0, start at T:
  - Shift_en at T+1.
  - 16 SCK toggles at T+1..T+16; 8 Sample_en on rising SCK; 7 further Shift_en on falling SCK.
  - done at T+17; idle=1 after.
- Mode 3, baud_div=3:
  - SCK_out idles 1; 8 Shift_en on falling edges, 8 Sample_en on rising edges.
  - SCK high/low phases are 4 cycles each.
  - done at T+68.
- Modes 1 and 2 at baud_div=1:
  - Check strobe/edge pairing per the rules above.
  - Check done at T+34.
  - Check SCK_out ends at CPOL.
- Robustness, baud_div=2:
  - Toggle CPOL/CPHA/baud_div and pulse start mid-transfer: waveform unchanged, no second transfer.
  - start held high through done: no restart in the done cycle, new transfer accepted in the following cycle.
- abort at the 5th SCK edge: next cycle SCK_out=CPOL, busy=0, no done, no strobes; a new start works normally.
- rst_n low mid-transfer (asynchronous, between clock edges): outputs take reset values immediately. After release, SCK_out follows CPOL and a full transfer completes correctly.
